// File: rtl/care_scheduler.sv
// care_scheduler: sequences periodic stat decay and round-robin care updates toward the stats datapath.
// Optional CARE_SCHED_RANDOM_DECAY_EN: decay magnitude becomes 1 + random[upd_sel].
module care_scheduler #(
    parameter logic [23:0] TICK_COUNT = 24'd10_000_000,
    parameter logic [3:0]  ACTION_AMT = 4'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] req,
    input  logic [7:0] random,
    input  logic       upd_ready,
    output logic       upd_valid,
    output logic [2:0] upd_sel,
    output logic       upd_dec,
    output logic [3:0] upd_amt,
    output logic [5:0] grant,
    output logic       busy,
    output logic       tick_overrun
);
    typedef enum logic [1:0] {IDLE, DECAY, CARE, COOLDOWN} state_t;

    state_t      state_reg, state_next;
    logic [23:0] tick_cnt_reg, tick_cnt_next;
    logic        tick;
    logic        tick_pend_reg, tick_pend_next;
    logic        tick_overrun_reg, tick_overrun_next;
    logic [2:0]  rr_ptr_reg, rr_ptr_next;
    logic        has_granted_reg, has_granted_next;
    logic [2:0]  cool_cnt_reg, cool_cnt_next;
    logic        upd_valid_reg, upd_valid_next;
    logic        upd_dec_reg, upd_dec_next;
    logic [2:0]  upd_sel_reg, upd_sel_next;
    logic [3:0]  upd_amt_reg, upd_amt_next;
    logic        accept, enter_decay;
    logic [2:0]  rr_start, winner, decay_next_sel;
    logic [3:0]  amt_first, amt_step;
    logic [2:0]  cand [6];

    assign tick           = (tick_cnt_reg == TICK_COUNT - 24'd1);
    assign tick_cnt_next  = tick ? 24'd0 : tick_cnt_reg + 24'd1;
    assign accept         = upd_valid_reg & upd_ready;
    assign enter_decay    = (state_reg == IDLE) & tick_pend_reg;
    assign decay_next_sel = upd_sel_reg + 3'd1;

    // A tick landing on the same cycle the pending one is consumed simply re-arms it.
    assign tick_pend_next    = tick | (tick_pend_reg & ~enter_decay);
    assign tick_overrun_next = tick_overrun_reg | (tick & tick_pend_reg & ~enter_decay);

`ifdef CARE_SCHED_RANDOM_DECAY_EN
    assign amt_first = 4'd1 + {3'd0, random[0]};
    assign amt_step  = 4'd1 + {3'd0, random[decay_next_sel]};
`else
    logic unused_random;
    assign unused_random = ^random;
    assign amt_first = 4'd1;
    assign amt_step  = 4'd1;
`endif

    // Until the first grant there is no "last granted", so the search starts at index 0.
    assign rr_start = (!has_granted_reg || rr_ptr_reg == 3'd5) ? 3'd0 : rr_ptr_reg + 3'd1;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_cand
            logic [3:0] sum;
            assign sum       = {1'b0, rr_start} + 4'(gi);
            assign cand[gi]  = (sum >= 4'd6) ? 3'(sum - 4'd6) : sum[2:0];
        end
    endgenerate

    always_comb begin
        winner = rr_start;
        for (int k = 5; k >= 0; k--) begin
            if (req[cand[k]]) winner = cand[k];
        end
    end

    always_comb begin
        state_next       = state_reg;
        rr_ptr_next      = rr_ptr_reg;
        has_granted_next = has_granted_reg;
        cool_cnt_next    = cool_cnt_reg;
        upd_valid_next   = upd_valid_reg;
        upd_sel_next     = upd_sel_reg;
        upd_dec_next     = upd_dec_reg;
        upd_amt_next     = upd_amt_reg;
        grant            = 6'd0;
        case (state_reg)
            IDLE: begin
                if (tick_pend_reg) begin
                    state_next     = DECAY;
                    upd_valid_next = 1'b1;
                    upd_sel_next   = 3'd0;
                    upd_dec_next   = 1'b1;
                    upd_amt_next   = amt_first;
                end else if (|req) begin
                    state_next     = CARE;
                    upd_valid_next = 1'b1;
                    upd_sel_next   = winner;
                    upd_dec_next   = 1'b0;
                    upd_amt_next   = ACTION_AMT;
                end
            end
            DECAY: begin
                if (accept) begin
                    if (upd_sel_reg == 3'd5) begin
                        state_next     = IDLE;
                        upd_valid_next = 1'b0;
                        upd_sel_next   = 3'd0;
                        upd_dec_next   = 1'b0;
                        upd_amt_next   = 4'd0;
                    end else begin
                        upd_sel_next = decay_next_sel;
                        upd_amt_next = amt_step;
                    end
                end
            end
            CARE: begin
                if (accept) begin
                    grant            = 6'd1 << upd_sel_reg;
                    rr_ptr_next      = upd_sel_reg;
                    has_granted_next = 1'b1;
                    state_next       = COOLDOWN;
                    cool_cnt_next    = 3'd0;
                    upd_valid_next   = 1'b0;
                    upd_sel_next     = 3'd0;
                    upd_amt_next     = 4'd0;
                end
            end
            COOLDOWN: begin
                if (cool_cnt_reg == 3'd7) state_next = IDLE;
                else cool_cnt_next = cool_cnt_reg + 3'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            tick_cnt_reg     <= 24'd0;
            tick_pend_reg    <= 1'b0;
            tick_overrun_reg <= 1'b0;
            rr_ptr_reg       <= 3'd0;
            has_granted_reg  <= 1'b0;
            cool_cnt_reg     <= 3'd0;
            upd_valid_reg    <= 1'b0;
            upd_sel_reg      <= 3'd0;
            upd_dec_reg      <= 1'b0;
            upd_amt_reg      <= 4'd0;
        end else begin
            state_reg        <= state_next;
            tick_cnt_reg     <= tick_cnt_next;
            tick_pend_reg    <= tick_pend_next;
            tick_overrun_reg <= tick_overrun_next;
            rr_ptr_reg       <= rr_ptr_next;
            has_granted_reg  <= has_granted_next;
            cool_cnt_reg     <= cool_cnt_next;
            upd_valid_reg    <= upd_valid_next;
            upd_sel_reg      <= upd_sel_next;
            upd_dec_reg      <= upd_dec_next;
            upd_amt_reg      <= upd_amt_next;
        end
    end

    assign upd_valid    = upd_valid_reg;
    assign upd_sel      = upd_sel_reg;
    assign upd_dec      = upd_dec_reg;
    assign upd_amt      = upd_amt_reg;
    assign busy         = (state_reg != IDLE);
    assign tick_overrun = tick_overrun_reg;
endmodule
